// File: rtl/fp_pkg.sv
// Shared single-precision constants and the accumulator sequencer state set.
// Imported by fp_accum_seq.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FP_W   = 1 + EXP_W + MANT_W;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IN   = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

endpackage

// File: rtl/fp_accum_seq.sv
// Folds a stream of singles into one sum through an external enable/done adder.
// Optional macro FP_ACCUM_BYPASS_FIRST_EN loads the first operand without an add.
module fp_accum_seq
  import fp_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_ops,
  input  logic [FP_W-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FP_W-1:0]    add_dataa,
  output logic [FP_W-1:0]    add_datab,
  output logic               add_enable,
  input  logic               add_done,
  input  logic [FP_W-1:0]    add_result,
  output logic [FP_W-1:0]    sum,
  output logic               sum_valid,
  output logic               busy
);

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [FP_W-1:0]    acc;
  logic [COUNT_W-1:0] remaining;
  logic               bypass;
  logic               last;

  assign last = (remaining == ONE);

`ifdef FP_ACCUM_BYPASS_FIRST_EN
  logic first;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      first <= 1'b1;
    end else if (state == ST_WAIT_IN && in_valid) begin
      first <= 1'b0;
    end
  end

  assign bypass = first;
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start && num_ops != '0)
          state_nxt = ST_WAIT_IN;
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          if (!bypass)
            state_nxt = ST_WAIT_DONE;
          else if (last)
            state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (add_done)
          state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!add_done)
          state_nxt = (remaining == '0) ? ST_IDLE
                                        : ST_WAIT_IN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_WAIT_IN);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      add_enable <= 1'b0;
      add_dataa  <= FP_POS_ZERO;
      add_datab  <= FP_POS_ZERO;
      sum        <= FP_POS_ZERO;
      sum_valid  <= 1'b0;
      acc        <= FP_POS_ZERO;
      remaining  <= '0;
    end else begin
      sum_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= num_ops;
            acc       <= FP_POS_ZERO;
            if (num_ops == '0) begin
              sum       <= FP_POS_ZERO;
              sum_valid <= 1'b1;
            end
          end
        end
        ST_WAIT_IN: begin
          if (in_valid && bypass) begin
            acc       <= in_data;
            remaining <= remaining - ONE;
            if (last) begin
              sum       <= in_data;
              sum_valid <= 1'b1;
            end
          end else if (in_valid) begin
            add_dataa  <= acc;
            add_datab  <= in_data;
            add_enable <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (add_done) begin
            acc        <= add_result;
            remaining  <= remaining - ONE;
            add_enable <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // done must fall before the next issue or the adder sees a stale handshake
          if (!add_done && remaining == '0) begin
            sum       <= acc;
            sum_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Upstream sequencer for the single-precision adder (clocked enable/done adder).
- Accepts a stream of IEEE-754 single-precision operands over a valid/ready interface.
- Drives the adder's dataa/datab/enable and watches its done/result to fold the stream into one running sum; the adder is instanced beside it at the level above.
- Presents the final sum with a one-cycle sum_valid pulse.

Parameters:
- COUNT_W, 8: width of the operand-count field; at most 2^COUNT_W-1 operands per job.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  start a job; sampled only in IDLE.
- num_ops  in  COUNT_W  number of operands in the job; latched on an accepted start.
- in_data  in  32  operand, IEEE-754 single.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts in_data; high only in WAIT_IN.
- add_dataa  out  32  to adder dataa (running accumulator).
- add_datab  out  32  to adder datab (current operand).
- add_enable  out  1  to adder enable.
- add_done  in  1  from adder done.
- add_result  in  32  from adder result.
- sum  out  32  final sum; holds until the next start is accepted.
- sum_valid  out  1  one-cycle pulse when sum is updated.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock; reset is synchronous and active-low on reset_n.
- Reset values (all registered outputs): state IDLE, add_enable 0, add_dataa 0, add_datab 0, sum 0, sum_valid 0, acc 0, remaining 0.
- Reset asserted mid-job aborts the job at that edge; add_enable drops, so the adder clears done on its own.
- in_ready is combinational: (state==WAIT_IN).
- busy is combinational: (state!=IDLE).
- States and transitions:
  - IDLE: on start, latch remaining<=num_ops and acc<=32'h0000_0000.
    - num_ops==0: stay IDLE, sum<=0, sum_valid<=1.
    - Otherwise go to WAIT_IN.
  - WAIT_IN: on in_valid&&in_ready, set add_dataa<=acc, add_datab<=in_data, add_enable<=1, go to WAIT_DONE.
  - WAIT_DONE: hold add_enable and operands until add_done==1. Then acc<=add_result, remaining<=remaining-1, add_enable<=0, go to RELEASE.
  - RELEASE: wait until add_done==0, so the adder's done has dropped before re-issue.
    - remaining==0: sum<=acc, sum_valid<=1, go to IDLE.
    - Otherwise go to WAIT_IN.
- sum_valid is cleared on every edge where it is not being set; it is never high for two consecutive cycles.
- start is ignored while busy. No start is accepted on the same edge that sum_valid is set.
- Zero handling relies on the adder: acc starts at +0, and the adder returns the other operand for a zero input.
- No rounding or exception handling here; the result is whatever the adder produces.
- Timing with an adder whose done rises the cycle after enable (as the current adder does) and in_valid held high:
  - 5 cycles per operand.
  - sum_valid is high in cycle S+5N, where S is the start edge.
- add_done stuck high or low hangs the FSM in WAIT_DONE or RELEASE; only reset recovers.

Optional Feature:
- FP_ACCUM_BYPASS_FIRST_EN
- Defined: the first accepted operand of a job loads acc directly and goes to RELEASE-equivalent bookkeeping without issuing an add. Exact behaviour:
  - acc<=in_data and remaining-1.
  - Go to WAIT_IN, or set sum/sum_valid if remaining becomes 0.
  - No add_enable toggle for that operand. Latency becomes 1 + 5(N-1) cycles for N≥1.
- Undefined: every operand is issued to the adder as above.

Decomposition:
- Shared package fp_pkg:
  - FP_W=32, EXP_W=8, MANT_W=23.
  - FP_POS_ZERO=32'h0000_0000.
  - State encoding constants ST_IDLE, ST_WAIT_IN, ST_WAIT_DONE, ST_RELEASE.
- No sub-module: the FSM and datapath are a single module. The adder is instanced by the parent, not inside this block.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles -> in_ready=0, busy=0, add_enable=0, sum=0, sum_valid=0.
- Basic sum: start with num_ops=3; stream 0x3F800000, 0x40000000, 0x40400000 (1.0, 2.0, 3.0) with in_valid always high, using the real adder -> sum=0x40C00000 (6.0), single sum_valid pulse at S+15, exactly 3 add_enable rising edges.
- Cancellation plus backpressure: num_ops=2 with 0x3FC00000 then 0xBFC00000, in_valid low for 4 cycles between them -> in_ready stays high while waiting, sum=0x00000000, busy low after the pulse.
- Zero-count and ignored start: num_ops=0 -> sum=0, sum_valid pulse at the next edge with no add_enable. Then start pulsed during a 2-op job -> ignored; the job completes with the correct sum.
- Handshake robustness: adder model holding done high for 3 extra cycles after enable drops -> FSM stays in RELEASE and does not re-assert add_enable until done=0; result still correct.
- Mid-job reset: reset_n=0 while in WAIT_DONE -> next edge add_enable=0, state IDLE. A new job of 1.0+1.0 afterwards gives 0x40000000. With FP_ACCUM_BYPASS_FIRST_EN, the same job issues exactly 1 add.
